// File: rtl/sram_readback_streamer_if.sv
// Control, byte-stream and SRAM read-bus bundle for sram_readback_streamer.
// master = streamer side, slave = the surrounding logic driving it.
interface sram_readback_streamer_if #(
  parameter int CPU_DW  = 8,
  parameter int SRAM_DW = 16,
  parameter int SRAM_AW = 16
);
  logic               start;
  logic               abort;
  logic [SRAM_AW-1:0] start_addr;
  logic [SRAM_AW:0]   word_count;
  logic               busy;
  logic               done;
  logic [CPU_DW-1:0]  out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SRAM_DW-1:0] sram_data_in;
  logic [SRAM_AW-1:0] sram_address;
  logic               sram_ce;
  logic               sram_oe;
  logic               sram_we;

  modport master (
    input  start, abort, start_addr, word_count, out_ready, sram_data_in,
    output busy, done, out_data, out_valid, sram_address, sram_ce, sram_oe, sram_we
  );

  modport slave (
    output start, abort, start_addr, word_count, out_ready, sram_data_in,
    input  busy, done, out_data, out_valid, sram_address, sram_ce, sram_oe, sram_we
  );
endinterface

// File: rtl/sram_readback_streamer.sv
// Reads a circular SRAM buffer back word by word and streams it LSB byte first.
// Latency: READ_WAIT+2 SRAM cycles per word; backpressure holds the byte and stalls the next read.
module sram_readback_streamer #(
  parameter int CPU_DW    = 8,
  parameter int SRAM_DW   = 16,
  parameter int SRAM_AW   = 16,
  parameter int READ_WAIT = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  sram_readback_streamer_if.master  bus
);
  localparam int BYTES = SRAM_DW / CPU_DW;
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WW    = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, EMIT, FIN} state_t;

  state_t             state;
  state_t             next_state;
  logic [SRAM_AW-1:0] addr;
  logic [SRAM_AW:0]   remaining;
  logic [SRAM_DW-1:0] word_buf;
  logic [SRAM_DW-1:0] word_shift;
  logic [IW-1:0]      byte_idx;
  logic [WW-1:0]      wait_cnt;
  logic               busy_q;
  logic               done_q;
  logic               busy_d;
  logic               done_d;
  logic               sram_sel;
  logic               out_vld;
  logic               start_ok;
  logic               emit_hs;
  logic               last_byte;
  logic               wait_over;

  assign start_ok  = (state == IDLE) && bus.start && !bus.abort;
  assign emit_hs   = (state == EMIT) && bus.out_ready;
  assign last_byte = (byte_idx == IW'(BYTES - 1));
  assign wait_over = (wait_cnt == WW'(READ_WAIT - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // abort outranks everything, including a start seen in the same IDLE cycle
  always_comb begin
    next_state = state;
    if (bus.abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) next_state = (bus.word_count == '0) ? FIN : ADDR;
        ADDR:    next_state = WAIT;
        WAIT:    if (wait_over) next_state = LATCH;
        LATCH:   next_state = EMIT;
        EMIT:    if (bus.out_ready && last_byte) next_state = (remaining == '0) ? FIN : ADDR;
        FIN:     next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    busy_d     = (next_state != IDLE);
    done_d     = (state == FIN) && !bus.abort;
    sram_sel   = (state == ADDR) || (state == WAIT) || (state == LATCH);
    out_vld    = (state == EMIT);
    word_shift = word_buf >> (byte_idx * CPU_DW);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
      word_buf  <= '0;
      byte_idx  <= '0;
      wait_cnt  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (start_ok) begin
        addr      <= bus.start_addr;
        remaining <= bus.word_count;
      end
      if (state == WAIT && !wait_over) wait_cnt <= wait_cnt + 1'b1;
      else                             wait_cnt <= '0;
      // address advances after the sample, so it is stable for the whole access
      if (state == LATCH) begin
        word_buf  <= bus.sram_data_in;
        remaining <= remaining - 1'b1;
        addr      <= addr + 1'b1;
      end
      if (bus.abort)    byte_idx <= '0;
      else if (emit_hs) byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.out_valid    = out_vld;
  assign bus.out_data     = word_shift[CPU_DW-1:0];
  assign bus.sram_address = addr;
  assign bus.sram_ce      = !sram_sel;
  assign bus.sram_oe      = !sram_sel;
  assign bus.sram_we      = 1'b1;
endmodule
